hazard_unit: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core. It produces the stall, freeze and flush controls consumed by the pipeline registers, including the `CLEAR` input of `id_ex`. It detects three conditions:
- load-use hazards between the ID and EX stages;
- taken branches resolved in EX;
- multi-cycle data-memory waits in MEM, with a timeout error.

It also keeps saturating performance counters for stall cycles and flush events.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/hazard_unit_if.sv | 37 +++
 rtl/sat_counter.sv | 23 ++
 rtl/hazard_unit.sv | 141 ++++++++++++++
 tb/tb_hazard_unit.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/riscv_pkg.sv
// Shared pipeline-control types and constants for the 5-stage core.
// Pure declarations: no logic, no latency, no flow control.
package riscv_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_ERR  = 2'd2
  } hz_state_t;

  localparam int         MEM_TIMEOUT_DEFAULT = 16;
  localparam logic [4:0] REG_ZERO            = 5'd0;

  // An operand only matters if the instruction actually reads it.
  function automatic logic src_match(input logic uses, input logic [4:0] rs,
                                     input logic [4:0] rd);
    return uses && (rs == rd);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Stage-side hazard inputs and pipeline-register controls of the hazard unit.
// Controls are combinational from the inputs; no handshake of its own.
interface hazard_unit_if;

  logic [4:0] rs1_ID;
  logic [4:0] rs2_ID;
  logic       uses_rs1_ID;
  logic       uses_rs2_ID;
  logic       MemRead_EX;
  logic [4:0] wrin_EX;
  logic       PCSrc_EX;
  logic       mem_req_MEM;
  logic       mem_ready_MEM;

  logic       PC_WRITE;
  logic       IF_ID_WRITE;
  logic       ID_EX_WRITE;
  logic       EX_MEM_WRITE;
  logic       IF_ID_CLEAR;
  logic       ID_EX_CLEAR;
  logic       MEM_WB_CLEAR;

  modport master (
    output rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, MemRead_EX, wrin_EX,
    output PCSrc_EX, mem_req_MEM, mem_ready_MEM,
    input  PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    input  IF_ID_CLEAR, ID_EX_CLEAR, MEM_WB_CLEAR
  );

  modport slave (
    input  rs1_ID, rs2_ID, uses_rs1_ID, uses_rs2_ID, MemRead_EX, wrin_EX,
    input  PCSrc_EX, mem_req_MEM, mem_ready_MEM,
    output PC_WRITE, IF_ID_WRITE, ID_EX_WRITE, EX_MEM_WRITE,
    output IF_ID_CLEAR, ID_EX_CLEAR, MEM_WB_CLEAR
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
// One-cycle latency from inc to count; inc is never refused.
module sat_counter #(
  parameter int size = 32
) (
  input  logic            CLK,
  input  logic            RESET_N,
  input  logic            inc,
  output logic [size-1:0] count
);

  localparam logic [size-1:0] ONE = {{(size-1){1'b0}}, 1'b1};
  localparam logic [size-1:0] MAX = {size{1'b1}};

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + ONE;
    end
  end

endmodule

// File: rtl/hazard_unit.sv
// Stall/freeze/flush control for the 5-stage pipeline, with a data-memory wait timeout.
// Controls are combinational (same-edge); mem_error and counters are registered (+1 cycle).
module hazard_unit
  import riscv_pkg::*;
#(
  parameter int size        = 32,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT
) (
  input  logic            CLK,
  input  logic            RESET_N,
  hazard_unit_if.slave    hz,
  output logic            mem_error,
  output logic [size-1:0] stall_cycles,
  output logic [size-1:0] flush_events
);

  localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  hz_state_t  state, state_nxt;
  logic [7:0] wait_cnt, wait_nxt;
  logic       err_set;
  logic       freeze;
  logic       load_use;
  logic       stall_inc;
  logic       flush_inc;
  logic       pc_write, if_id_write, id_ex_write, ex_mem_write;
  logic       if_id_clear, id_ex_clear, mem_wb_clear;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state     <= RUN;
      wait_cnt  <= 8'd0;
      mem_error <= 1'b0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (err_set) begin
        mem_error <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    wait_nxt     = wait_cnt;
    err_set      = 1'b0;
    pc_write     = 1'b1;
    if_id_write  = 1'b1;
    id_ex_write  = 1'b1;
    ex_mem_write = 1'b1;
    if_id_clear  = 1'b0;
    id_ex_clear  = 1'b0;
    mem_wb_clear = 1'b0;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;

    freeze   = hz.mem_req_MEM && !hz.mem_ready_MEM && (state != MEM_ERR);
    load_use = hz.MemRead_EX && (hz.wrin_EX != REG_ZERO) &&
               (src_match(hz.uses_rs1_ID, hz.rs1_ID, hz.wrin_EX) ||
                src_match(hz.uses_rs2_ID, hz.rs2_ID, hz.wrin_EX));

    case (state)
      RUN: begin
        if (freeze) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = 8'd1;
        end
      end
      MEM_WAIT: begin
        if (!hz.mem_req_MEM || hz.mem_ready_MEM) begin
          state_nxt = RUN;
          wait_nxt  = 8'd0;
        end else if (wait_cnt == WAIT_LAST) begin
          // This is the MEM_TIMEOUT-th frozen cycle; give up on the access.
          state_nxt = MEM_ERR;
          err_set   = 1'b1;
        end else begin
          wait_nxt = wait_cnt + 8'd1;
        end
      end
      MEM_ERR: begin
        state_nxt = MEM_ERR;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = 8'd0;
      end
    endcase

    // A branch held under a freeze simply falls through to here once memory is ready.
    if (state == MEM_ERR) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      if_id_clear  = 1'b1;
      id_ex_clear  = 1'b1;
      mem_wb_clear = 1'b1;
      stall_inc    = 1'b1;
    end else if (freeze) begin
      pc_write     = 1'b0;
      if_id_write  = 1'b0;
      id_ex_write  = 1'b0;
      ex_mem_write = 1'b0;
      mem_wb_clear = 1'b1;
      stall_inc    = 1'b1;
    end else if (hz.PCSrc_EX) begin
      if_id_clear = 1'b1;
      id_ex_clear = 1'b1;
      flush_inc   = 1'b1;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_clear = 1'b1;
      stall_inc   = 1'b1;
    end
  end

  assign hz.PC_WRITE     = pc_write;
  assign hz.IF_ID_WRITE  = if_id_write;
  assign hz.ID_EX_WRITE  = id_ex_write;
  assign hz.EX_MEM_WRITE = ex_mem_write;
  assign hz.IF_ID_CLEAR  = if_id_clear;
  assign hz.ID_EX_CLEAR  = id_ex_clear;
  assign hz.MEM_WB_CLEAR = mem_wb_clear;

  sat_counter #(.size(size)) u_stall_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (stall_inc),
    .count   (stall_cycles)
  );

  sat_counter #(.size(size)) u_flush_cnt (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .inc     (flush_inc),
    .count   (flush_events)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: vector table for single-cycle behaviour,
// hand-written sequences for memory wait, timeout/reset and counter saturation.
module tb_hazard_unit;
  import riscv_pkg::*;

  localparam int SZ = 4;
  localparam int MT = 4;

  // Control word order: PC_WRITE IF_ID_WRITE ID_EX_WRITE EX_MEM_WRITE IF_ID_CLEAR ID_EX_CLEAR MEM_WB_CLEAR
  localparam logic [6:0] C_IDLE   = 7'b1111_000;
  localparam logic [6:0] C_LU     = 7'b0011_010;
  localparam logic [6:0] C_FLUSH  = 7'b1111_110;
  localparam logic [6:0] C_FREEZE = 7'b0000_001;
  localparam logic [6:0] C_ERR    = 7'b0000_111;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          mem_error;
  logic [SZ-1:0] stall_cycles;
  logic [SZ-1:0] flush_events;
  int            checks = 0;
  int            failures = 0;
  int            exp_st;
  int            exp_fl;

  always #5 CLK = ~CLK;

  hazard_unit_if hz ();

  hazard_unit #(.size(SZ), .MEM_TIMEOUT(MT)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .hz           (hz),
    .mem_error    (mem_error),
    .stall_cycles (stall_cycles),
    .flush_events (flush_events)
  );

  typedef struct {
    string      name;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       mr;
    logic [4:0] wrin;
    logic       pcsrc;
    logic       req;
    logic       rdy;
    logic [6:0] ctrl;
    int         st;
    int         fl;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [6:0] ctrl_now();
    return {hz.PC_WRITE, hz.IF_ID_WRITE, hz.ID_EX_WRITE, hz.EX_MEM_WRITE,
            hz.IF_ID_CLEAR, hz.ID_EX_CLEAR, hz.MEM_WB_CLEAR};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    hz.rs1_ID        = v.rs1;
    hz.rs2_ID        = v.rs2;
    hz.uses_rs1_ID   = v.u1;
    hz.uses_rs2_ID   = v.u2;
    hz.MemRead_EX    = v.mr;
    hz.wrin_EX       = v.wrin;
    hz.PCSrc_EX      = v.pcsrc;
    hz.mem_req_MEM   = v.req;
    hz.mem_ready_MEM = v.rdy;
  endtask

  task automatic next_cycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RESET_N = 1'b0;
    drive(vecs[0]);
    #2;
    RESET_N = 1'b1;
    next_cycle();
  endtask

  initial begin
    vecs[0] = '{"idle",       5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE,  0, 0};
    vecs[1] = '{"lu_rs2",     5'd3, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_LU,    1, 0};
    vecs[2] = '{"lu_rs1",     5'd7, 5'd9, 1'b1, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0, C_LU,    1, 0};
    vecs[3] = '{"x0",         5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, C_IDLE,  0, 0};
    vecs[4] = '{"unused_rs1", 5'd5, 5'd2, 1'b0, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_IDLE,  0, 0};
    vecs[5] = '{"not_load",   5'd5, 5'd5, 1'b1, 1'b1, 1'b0, 5'd5, 1'b0, 1'b0, 1'b0, C_IDLE,  0, 0};
    vecs[6] = '{"br_and_lu",  5'd1, 5'd5, 1'b1, 1'b1, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, C_FLUSH, 0, 1};
    vecs[7] = '{"branch",     5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, C_FLUSH, 0, 1};
    vecs[8] = '{"lu_mem_rdy", 5'd12,5'd4, 1'b1, 1'b0, 1'b1, 5'd12,1'b0, 1'b1, 1'b1, C_LU,    1, 0};
    vecs[9] = '{"no_match",   5'd6, 5'd4, 1'b1, 1'b1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, C_IDLE,  0, 0};

    // Reset state
    RESET_N = 1'b0;
    drive(vecs[0]);
    #12;
    check("rst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    check("rst_mem_error", 32'(mem_error), 32'd0);
    check("rst_stall", 32'(stall_cycles), 32'd0);
    check("rst_flush", 32'(flush_events), 32'd0);
    check("rst_state", 32'(dut.state), 32'(RUN));
    check("rst_wait_cnt", 32'(dut.wait_cnt), 32'd0);
    RESET_N = 1'b1;
    next_cycle();

    // Single-cycle vectors
    exp_st = 0;
    exp_fl = 0;
    for (int i = 0; i < 10; i++) begin
      drive(vecs[i]);
      #2;
      check({vecs[i].name, "_ctrl"}, 32'(ctrl_now()), 32'(vecs[i].ctrl));
      next_cycle();
      exp_st += vecs[i].st;
      exp_fl += vecs[i].fl;
      check({vecs[i].name, "_stall"}, 32'(stall_cycles), 32'(exp_st));
      check({vecs[i].name, "_flush"}, 32'(flush_events), 32'(exp_fl));
    end
    drive(vecs[0]);

    // Memory wait of 3 cycles with a branch held across the freeze
    do_reset();
    hz.mem_req_MEM   = 1'b1;
    hz.mem_ready_MEM = 1'b0;
    hz.PCSrc_EX      = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      #2;
      check($sformatf("wait_c%0d_ctrl", c), 32'(ctrl_now()), 32'(C_FREEZE));
      next_cycle();
      check($sformatf("wait_c%0d_state", c), 32'(dut.state), 32'(MEM_WAIT));
    end
    hz.mem_ready_MEM = 1'b1;
    #2;
    check("wait_release_ctrl", 32'(ctrl_now()), 32'(C_FLUSH));
    next_cycle();
    check("wait_release_state", 32'(dut.state), 32'(RUN));
    check("wait_stall", 32'(stall_cycles), 32'd3);
    check("wait_flush", 32'(flush_events), 32'd1);
    check("wait_no_error", 32'(mem_error), 32'd0);
    drive(vecs[0]);

    // Timeout into MEM_ERR, then asynchronous reset mid-cycle
    do_reset();
    hz.mem_req_MEM   = 1'b1;
    hz.mem_ready_MEM = 1'b0;
    for (int c = 1; c <= MT; c++) begin
      #2;
      check($sformatf("to_c%0d_ctrl", c), 32'(ctrl_now()), 32'(C_FREEZE));
      check($sformatf("to_c%0d_err", c), 32'(mem_error), 32'd0);
      next_cycle();
    end
    #2;
    check("to_err_flag", 32'(mem_error), 32'd1);
    check("to_err_ctrl", 32'(ctrl_now()), 32'(C_ERR));
    check("to_err_state", 32'(dut.state), 32'(MEM_ERR));
    next_cycle();
    check("to_err_stall", 32'(stall_cycles), 32'd5);
    hz.mem_ready_MEM = 1'b1;
    hz.mem_req_MEM   = 1'b0;
    hz.PCSrc_EX      = 1'b1;
    #2;
    check("to_locked_ctrl", 32'(ctrl_now()), 32'(C_ERR));
    check("to_locked_flush", 32'(flush_events), 32'd0);
    drive(vecs[0]);
    RESET_N = 1'b0;
    #1;
    check("to_rst_err", 32'(mem_error), 32'd0);
    check("to_rst_stall", 32'(stall_cycles), 32'd0);
    check("to_rst_state", 32'(dut.state), 32'(RUN));
    check("to_rst_ctrl", 32'(ctrl_now()), 32'(C_IDLE));
    RESET_N = 1'b1;
    next_cycle();

    // Saturation of the stall counter
    do_reset();
    drive(vecs[1]);
    for (int c = 1; c <= 20; c++) begin
      next_cycle();
      if (c == 14) check("sat_c14", 32'(stall_cycles), 32'd14);
    end
    #2;
    check("sat_ctrl", 32'(ctrl_now()), 32'(C_LU));
    check("sat_stall", 32'(stall_cycles), 32'd15);
    check("sat_flush", 32'(flush_events), 32'd0);
    drive(vecs[0]);
    next_cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
